// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick helper for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_NREQ = 8;

  typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } rr_pick_t;

  // Search wraps modulo MAX_NREQ; unused upper valid bits are zero, so the
  // visiting order matches a cyclic search modulo the real requester count.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input req_idx_t ptr);
    rr_pick_t res;
    req_idx_t cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      cand = ptr + req_idx_t'(k);
      if (!res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Single-port memory interface: command side driven by the master.
interface mem_if #(
  parameter int unsigned ALEN = 10,
  parameter int unsigned DLEN = 32
);
  logic            wen;
  logic [ALEN-1:0] waddr;
  logic [DLEN-1:0] wdata;
  logic            ren;
  logic [ALEN-1:0] raddr;
  logic [DLEN-1:0] rdata;
  logic            rvalid;

  modport M (output wen, waddr, wdata, ren, raddr, input rdata, rvalid);
  modport S (input wen, waddr, wdata, ren, raddr, output rdata, rvalid);
endinterface

// File: rtl/mem_arb_id_fifo.sv
// Synchronous FIFO of requester IDs for reads awaiting memory data.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  req_idx_t din,
  output req_idx_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  req_idx_t        slot_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= din;
  end

  assign dout  = slot_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters;
// read data is routed back through an in-order ID FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ALEN      = 10,
  parameter int unsigned DLEN      = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ-1:0][ALEN-1:0] req_addr,
  input  logic [NREQ-1:0][DLEN-1:0] req_wdata,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DLEN-1:0]           rsp_rdata,
  output logic                      err,
  mem_if.M                          mem
);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("mem_port_arbiter: NREQ must be within 2..MAX_NREQ");
  end
  if (MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0) begin : g_bad_outst
    $error("mem_port_arbiter: MAX_OUTST must be a power of 2");
  end
  if (mem.ALEN != ALEN || mem.DLEN != DLEN) begin : g_bad_width
    $error("mem_port_arbiter: ALEN/DLEN must match mem_if");
  end

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  req_idx_t             fifo_head;
  logic [MAX_NREQ-1:0]  elig;
  rr_pick_t             pick;
  logic                 grant, grant_we;
  req_idx_t             rr_ptr_q, rr_ptr_d;
  logic                 err_q;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DLEN-1:0]      rsp_rdata_q;

  // Eligibility uses the registered FIFO state, so a same-cycle pop never
  // frees a slot for a read in that cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & (req_we[i] | ~fifo_full);
    end
    pick      = rr_pick(elig, rr_ptr_q);
    grant     = pick.found & ~rst;
    grant_we  = 1'b0;
    req_ready = '0;
    mem.wen   = 1'b0;
    mem.waddr = '0;
    mem.wdata = '0;
    mem.ren   = 1'b0;
    mem.raddr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant && pick.idx == req_idx_t'(i)) begin
        req_ready[i] = 1'b1;
        grant_we     = req_we[i];
        if (req_we[i]) begin
          mem.wen   = 1'b1;
          mem.waddr = req_addr[i];
          mem.wdata = req_wdata[i];
        end else begin
          mem.ren   = 1'b1;
          mem.raddr = req_addr[i];
        end
      end
    end
    fifo_push = grant & ~grant_we;
    rr_ptr_d  = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (pick.idx == req_idx_t'(NREQ - 1)) ? '0 : pick.idx + req_idx_t'(1);
    end
  end

  always_comb begin
    fifo_pop    = mem.rvalid & ~fifo_empty;
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = fifo_pop & (fifo_head == req_idx_t'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      if (fifo_pop) rsp_rdata_q <= mem.rdata;
      if (mem.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (pick.idx),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;

endmodule
